prior_cov_dimpar: RTL and testbench

//   Parametrised successor of the 2x2 semi-parallel prior-covariance unit.

---
 rtl/kf_fxp_pkg.sv | 44 ++++
 rtl/fxp_mul.sv | 12 +
 rtl/kf_dot_engine.sv | 36 +++
 rtl/prior_cov_dimpar.sv | 157 +++++++++++++++
 tb/tb_prior_cov_dimpar.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kf_fxp_pkg.sv
// Fixed-point helpers shared by the Kalman-filter predict blocks: FSM encoding,
// accumulator sizing, flat-matrix indexing and N-bit narrowing (wrap or saturate).
package kf_fxp_pkg;

  // Widest supported word; helpers work at this width and callers keep the low bits
  localparam int unsigned N_MAX = 32;
  localparam int unsigned ACC_W = 2*N_MAX + 2;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [N_MAX-1:0] word_t;

  typedef enum logic [1:0] {IDLE, CALC_T, CALC_S, FIN} state_t;

  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned dim);
    return r*dim + c;
  endfunction

  function automatic logic fxp_out_of_range(input acc_t acc, input int unsigned n,
                                            input int unsigned frac);
    acc_t sh;
    acc_t hi;
    sh = acc >>> frac;
    hi = (acc_t'(1) <<< (n-1)) - acc_t'(1);
    return (sh > hi) || (sh < (-hi - acc_t'(1)));
  endfunction

  // Floor-truncate by frac; with sat clear the low n bits are a plain wrap
  function automatic word_t fxp_narrow(input acc_t acc, input int unsigned n,
                                       input int unsigned frac, input logic sat);
    acc_t  sh;
    acc_t  hi;
    acc_t  lo;
    word_t res;
    sh  = acc >>> frac;
    hi  = (acc_t'(1) <<< (n-1)) - acc_t'(1);
    lo  = -hi - acc_t'(1);
    res = word_t'(sh);
    if (sat && (sh > hi)) res = word_t'(hi);
    if (sat && (sh < lo)) res = word_t'(lo);
    return res;
  endfunction

endpackage

// File: rtl/fxp_mul.sv
// Full-precision signed fixed-point multiplier (2N-bit product, no scaling).
module fxp_mul #(
  parameter int N = 20
) (
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic signed [2*N-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/kf_dot_engine.sv
// Combinational DIM-wide dot product: DIM full-precision multipliers and a
// two-level adder tree producing a guarded 2N+2 bit sum.
module kf_dot_engine #(
  parameter int N   = 20,
  parameter int DIM = 2
) (
  input  logic [DIM*N-1:0]      x_flat,
  input  logic [DIM*N-1:0]      y_flat,
  output logic signed [2*N+1:0] sum
);

  localparam int unsigned AW = 2*N + 2;

  logic signed [2*N-1:0] prod [DIM];
  logic signed [AW-1:0]  leaf [4];
  logic signed [AW-1:0]  s01;
  logic signed [AW-1:0]  s23;

  for (genvar k = 0; k < DIM; k++) begin : g_mul
    fxp_mul #(.N(N)) u_mul (
      .a (x_flat[k*N +: N]),
      .b (y_flat[k*N +: N]),
      .p (prod[k])
    );
  end

  // Unused leaves stay zero so the tree shape is fixed for DIM 2..4
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) leaf[k] = '0;
    for (int unsigned k = 0; k < DIM; k++) leaf[k] = AW'(prod[k]);
    s01 = leaf[0] + leaf[1];
    s23 = leaf[2] + leaf[3];
    sum = s01 + s23;
  end

endmodule

// File: rtl/prior_cov_dimpar.sv
// Prior covariance S = A*P*A^T + Q over one shared DIM-wide dot engine.
// Optional saturation with sticky ovf is enabled by defining PRIOR_COV_SAT_EN.
module prior_cov_dimpar
  import kf_fxp_pkg::*;
#(
  parameter int N    = 20,
  parameter int FRAC = 10,
  parameter int DIM  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIM*DIM*N-1:0] a_flat,
  input  logic [DIM*DIM*N-1:0] p_flat,
  input  logic [DIM*DIM*N-1:0] q_flat,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic [DIM*DIM*N-1:0] P_PRIOR_FLAT
);

  localparam int unsigned AW = 2*N + 2;
  localparam int unsigned MW = DIM*DIM*N;
  localparam int unsigned CW = (DIM > 1) ? $clog2(DIM) : 1;

`ifdef PRIOR_COV_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  state_t state, state_d;

  logic [MW-1:0]        a_r, p_r, q_r, t_r, s_r, out_r;
  logic [CW-1:0]        ri, ci;
  logic                 last;
  logic [DIM*N-1:0]     x_vec, y_vec;
  logic [N-1:0]         q_el;
  logic signed [AW-1:0] dot, q_sh, acc;
  logic [N-1:0]         nv;

  assign last = (ri == CW'(DIM-1)) && (ci == CW'(DIM-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = CALC_T;
      CALC_T:  if (last)  state_d = CALC_S;
      CALC_S:  if (last)  state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pass 1 forms T(i,j) = P(i,:).A(j,:); pass 2 forms S(i,j) = A(i,:).T(:,j)
  always_comb begin
    x_vec = '0;
    y_vec = '0;
    for (int unsigned k = 0; k < DIM; k++) begin
      if (state == CALC_S) begin
        x_vec[k*N +: N] = a_r[idx(32'(ri), k, DIM)*N +: N];
        y_vec[k*N +: N] = t_r[idx(k, 32'(ci), DIM)*N +: N];
      end else begin
        x_vec[k*N +: N] = p_r[idx(32'(ri), k, DIM)*N +: N];
        y_vec[k*N +: N] = a_r[idx(32'(ci), k, DIM)*N +: N];
      end
    end
  end

  kf_dot_engine #(.N(N), .DIM(DIM)) u_dot (
    .x_flat (x_vec),
    .y_flat (y_vec),
    .sum    (dot)
  );

  always_comb begin
    q_el = q_r[idx(32'(ri), 32'(ci), DIM)*N +: N];
    q_sh = $signed({{(AW-N){q_el[N-1]}}, q_el}) <<< FRAC;
    acc  = dot;
    if (state == CALC_S) acc = dot + q_sh;
    nv   = N'(fxp_narrow(acc_t'(acc), N, FRAC, SAT_EN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      p_r   <= '0;
      q_r   <= '0;
      t_r   <= '0;
      s_r   <= '0;
      out_r <= '0;
      ri    <= '0;
      ci    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a_flat;
            p_r  <= p_flat;
            q_r  <= q_flat;
            ri   <= '0;
            ci   <= '0;
            busy <= 1'b1;
          end
        end
        CALC_T, CALC_S: begin
          if (state == CALC_T) t_r[idx(32'(ri), 32'(ci), DIM)*N +: N] <= nv;
          else                 s_r[idx(32'(ri), 32'(ci), DIM)*N +: N] <= nv;
          // Column-major walk: row index runs fastest
          if (last) begin
            ri <= '0;
            ci <= '0;
          end else if (ri == CW'(DIM-1)) begin
            ri <= '0;
            ci <= ci + CW'(1);
          end else begin
            ri <= ri + CW'(1);
          end
        end
        FIN: begin
          out_r <= s_r;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign P_PRIOR_FLAT = out_r;

`ifdef PRIOR_COV_SAT_EN
  logic clamp;
  logic ovf_r;

  assign clamp = fxp_out_of_range(acc_t'(acc), N, FRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           ovf_r <= 1'b0;
    else if ((state == IDLE) && start)                    ovf_r <= 1'b0;
    else if (((state == CALC_T) || (state == CALC_S)) && clamp) ovf_r <= 1'b1;
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_prior_cov_dimpar.sv
// Scoreboard bench for prior_cov_dimpar at DIM=2 and DIM=3 against an integer
// matrix model of S = A*P*A^T + Q (saturating when PRIOR_COV_SAT_EN is defined).
module tb_prior_cov_dimpar;

  localparam int N    = 20;
  localparam int FRAC = 10;
  localparam int ONE  = 1 << FRAC;
  localparam int W2   = 4*N;
  localparam int W3   = 9*N;
  localparam int WM   = 16*N;

  typedef int mat_t [16];
  typedef struct {
    logic [WM-1:0] s;
    logic          ovf;
    int            cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start2 = 1'b0, start3 = 1'b0;
  logic [W2-1:0] a2 = '0, p2 = '0, q2 = '0, pp2;
  logic [W3-1:0] a3 = '0, p3 = '0, q3 = '0, pp3;
  logic busy2, done2, ovf2, busy3, done3, ovf3;

  prior_cov_dimpar #(.N(N), .FRAC(FRAC), .DIM(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_flat(a2), .p_flat(p2), .q_flat(q2),
    .busy(busy2), .done(done2), .ovf(ovf2), .P_PRIOR_FLAT(pp2)
  );

  prior_cov_dimpar #(.N(N), .FRAC(FRAC), .DIM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_flat(a3), .p_flat(p3), .q_flat(q3),
    .busy(busy3), .done(done3), .ovf(ovf3), .P_PRIOR_FLAT(pp3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t sb2[$], sb3[$];
  exp_t e2, e3;
  logic [WM-1:0] held2 = '0, held3 = '0;

  function automatic longint narrow(input longint v, output logic clamp);
    longint sh, hi, lo, res;
    logic [N-1:0] b;
    sh = v >>> FRAC;
    hi = (longint'(1) <<< (N-1)) - 1;
    lo = -hi - 1;
    clamp = 1'b0;
    b = sh[N-1:0];
    res = longint'($signed(b));
`ifdef PRIOR_COV_SAT_EN
    if (sh > hi) begin clamp = 1'b1; res = hi; end
    if (sh < lo) begin clamp = 1'b1; res = lo; end
`endif
    return res;
  endfunction

  function automatic exp_t model(input int dim, input mat_t a, input mat_t p, input mat_t q);
    longint t [16];
    longint acc, s;
    logic c;
    exp_t e;
    e.s = '0; e.ovf = 1'b0; e.cyc = 0;
    for (int i = 0; i < 16; i++) t[i] = 0;
    for (int i = 0; i < dim; i++)
      for (int j = 0; j < dim; j++) begin
        acc = 0;
        for (int k = 0; k < dim; k++) acc += longint'(p[i*dim+k]) * longint'(a[j*dim+k]);
        t[i*dim+j] = narrow(acc, c);
        e.ovf |= c;
      end
    for (int i = 0; i < dim; i++)
      for (int j = 0; j < dim; j++) begin
        acc = longint'(q[i*dim+j]) * ONE;
        for (int k = 0; k < dim; k++) acc += longint'(a[i*dim+k]) * t[k*dim+j];
        s = narrow(acc, c);
        e.ovf |= c;
        e.s[(i*dim+j)*N +: N] = N'(s);
      end
    return e;
  endfunction

  function automatic logic [WM-1:0] pack(input int dim, input mat_t m);
    logic [WM-1:0] r;
    r = '0;
    for (int i = 0; i < dim*dim; i++) r[i*N +: N] = N'(m[i]);
    return r;
  endfunction

  function automatic mat_t zero_m();
    mat_t m;
    for (int i = 0; i < 16; i++) m[i] = 0;
    return m;
  endfunction

  function automatic mat_t rnd_m(input int dim, input bit wide);
    mat_t m;
    m = zero_m();
    for (int i = 0; i < dim*dim; i++)
      m[i] = wide ? int'($urandom_range(0, (1 << N) - 1)) - (1 << (N-1))
                  : int'($urandom_range(0, 8*ONE)) - 4*ONE;
    return m;
  endfunction

  task automatic chk_vec(input string name, input logic [WM-1:0] act, input logic [WM-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done2) begin
        if (sb2.size() == 0) chk_int("done_dim2_unexpected", 1, 0);
        else begin
          e2 = sb2.pop_front();
          chk_vec("s_dim2", WM'(pp2), e2.s);
          chk_int("ovf_dim2", int'(ovf2), int'(e2.ovf));
          chk_int("latency_dim2", cyc - e2.cyc, 2*2*2 + 1);
          held2 = e2.s;
        end
      end else chk_vec("hold_dim2", WM'(pp2), held2);
      if (done3) begin
        if (sb3.size() == 0) chk_int("done_dim3_unexpected", 1, 0);
        else begin
          e3 = sb3.pop_front();
          chk_vec("s_dim3", WM'(pp3), e3.s);
          chk_int("ovf_dim3", int'(ovf3), int'(e3.ovf));
          chk_int("latency_dim3", cyc - e3.cyc, 2*3*3 + 1);
          held3 = e3.s;
        end
      end else chk_vec("hold_dim3", WM'(pp3), held3);
    end
  end

  // Called at a negedge with the target unit idle (or in its done cycle)
  task automatic issue(input int dim, input mat_t a, input mat_t p, input mat_t q);
    exp_t e;
    logic [WM-1:0] ta, tp, tq;
    ta = pack(dim, a);
    tp = pack(dim, p);
    tq = pack(dim, q);
    e = model(dim, a, p, q);
    e.cyc = cyc + 1;
    if (dim == 2) begin
      a2 = ta[W2-1:0]; p2 = tp[W2-1:0]; q2 = tq[W2-1:0]; start2 = 1'b1;
      sb2.push_back(e);
    end else begin
      a3 = ta[W3-1:0]; p3 = tp[W3-1:0]; q3 = tq[W3-1:0]; start3 = 1'b1;
      sb3.push_back(e);
    end
    @(negedge clk);
    start2 = 1'b0;
    start3 = 1'b0;
    scramble();
    if (dim == 2) chk_int("busy_after_accept_dim2", int'(busy2), 1);
    else          chk_int("busy_after_accept_dim3", int'(busy3), 1);
  endtask

  task automatic scramble();
    a2 = W2'({$urandom(), $urandom(), $urandom()});
    p2 = W2'({$urandom(), $urandom(), $urandom()});
    q2 = W2'({$urandom(), $urandom(), $urandom()});
    a3 = W3'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    p3 = W3'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    q3 = W3'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic wait_done(input int dim);
    int n;
    n = 0;
    while (!(dim == 2 ? done2 : done3) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!(dim == 2 ? done2 : done3)) chk_int("done_timeout", 0, 1);
    else if (dim == 2) chk_int("busy_in_done_dim2", int'(busy2), 0);
    else               chk_int("busy_in_done_dim3", int'(busy3), 0);
  endtask

  initial begin
    mat_t a, p, q, lit;

    #1;
    chk_vec("reset_out_dim2", WM'(pp2), '0);
    chk_int("reset_busy", int'(busy2), 0);
    chk_int("reset_done", int'(done2), 0);
    chk_int("reset_ovf", int'(ovf2), 0);
    chk_vec("reset_out_dim3", WM'(pp3), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // A=I, P=diag(2,3), Q=0.5*I
    a = zero_m(); p = zero_m(); q = zero_m();
    a[0] = ONE; a[3] = ONE; p[0] = 2*ONE; p[3] = 3*ONE; q[0] = ONE/2; q[3] = ONE/2;
    issue(2, a, p, q);
    wait_done(2);
    lit = zero_m(); lit[0] = 2560; lit[3] = 3584;
    chk_vec("diag_raw", WM'(pp2), pack(2, lit));
    @(negedge clk);

    // A=[[1,1],[0,1]], P=I, Q=0
    a = zero_m(); p = zero_m(); q = zero_m();
    a[0] = ONE; a[1] = ONE; a[3] = ONE; p[0] = ONE; p[3] = ONE;
    issue(2, a, p, q);
    wait_done(2);
    lit = zero_m(); lit[0] = 2048; lit[1] = 1024; lit[2] = 1024; lit[3] = 1024;
    chk_vec("shear_raw", WM'(pp2), pack(2, lit));

    // Back-to-back start in the done cycle, with stray starts while busy
    issue(2, rnd_m(2, 0), rnd_m(2, 0), rnd_m(2, 0));
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    wait_done(2);
    issue(2, rnd_m(2, 0), rnd_m(2, 0), rnd_m(2, 0));
    wait_done(2);
    @(negedge clk);

    // A=30*I, P=I, Q=0 overflows S(0,0)
    a = zero_m(); p = zero_m(); q = zero_m();
    a[0] = 30*ONE; a[3] = 30*ONE; p[0] = ONE; p[3] = ONE;
    issue(2, a, p, q);
    wait_done(2);
`ifdef PRIOR_COV_SAT_EN
    chk_int("sat_s00", int'($signed(pp2[N-1:0])), (1 << (N-1)) - 1);
    chk_int("sat_ovf", int'(ovf2), 1);
`else
    chk_int("wrap_s00", int'($signed(pp2[N-1:0])), (900 - 1024) * 1024);
    chk_int("wrap_ovf", int'(ovf2), 0);
`endif
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      issue(2, rnd_m(2, i[0]), rnd_m(2, i[0]), rnd_m(2, i[0]));
      wait_done(2);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    // Reset mid-job discards the job and clears outputs at once
    issue(2, rnd_m(2, 0), rnd_m(2, 0), rnd_m(2, 0));
    @(negedge clk);
    @(negedge clk);
    #2;
    sb2.delete();
    held2 = '0;
    held3 = '0;
    rst_n = 1'b0;
    #1;
    chk_int("midreset_busy", int'(busy2), 0);
    chk_int("midreset_done", int'(done2), 0);
    chk_int("midreset_ovf", int'(ovf2), 0);
    chk_vec("midreset_out", WM'(pp2), '0);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    issue(2, rnd_m(2, 0), rnd_m(2, 0), rnd_m(2, 0));
    wait_done(2);
    @(negedge clk);

    // DIM=3: A=I, P=diag(1,2,3), Q=I
    a = zero_m(); p = zero_m(); q = zero_m();
    a[0] = ONE; a[4] = ONE; a[8] = ONE;
    p[0] = ONE; p[4] = 2*ONE; p[8] = 3*ONE;
    q[0] = ONE; q[4] = ONE; q[8] = ONE;
    issue(3, a, p, q);
    wait_done(3);
    lit = zero_m(); lit[0] = 2*ONE; lit[4] = 3*ONE; lit[8] = 4*ONE;
    chk_vec("dim3_diag", WM'(pp3), pack(3, lit));
    for (int i = 0; i < 4; i++) begin
      issue(3, rnd_m(3, i[0]), rnd_m(3, i[0]), rnd_m(3, i[0]));
      wait_done(3);
    end

    repeat (3) @(negedge clk);
    chk_int("scoreboard_drained", sb2.size() + sb3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
